power_seq_ctrl: RTL
===================

POWER_SEQ_CTRL -- requirements
Module: power_seq_ctrl

Interface
REQ-001 Parameter RAMP_CYC, default 16, cycles the PMOS header stays on before pgood is checked; legal range 1..255.
REQ-002 Parameter ISO_CYC, default 4, cycles between isolation change and next sequencing step; legal range 1..255.
REQ-003 Parameter CNT_W, default 8, width of the shared down-counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 pwr_req  input  1  level request: 1 = power the gated domain (VDD/VSS of DUT), 0 = power it down.
REQ-007 pgood  input  1  supply-good sense of the gated VDD rail, synchronous to clk.
REQ-008 hdr_en_b  output  1  gate of the PMOS supply header; 0 = header on (rail connected).
REQ-009 iso_en  output  1  1 = DUT outputs clamped/isolated.
REQ-010 dut_rst  output  1  1 = DUT held in reset.
REQ-011 pwr_ack  output  1  1 = domain fully on and usable.
REQ-012 busy  output  1  1 = sequence in progress (any state other than OFF, ON, FAULT).
REQ-013 fault  output  1  1 = pgood failed after ramp.

Function
REQ-014 Moore FSM states: OFF, RAMP, DEISO, ON, ISO, DRAIN, FAULT; all outputs decoded from registered state only, no input-to-output combinational path.
REQ-015 Output decode: OFF/DRAIN/FAULT: hdr_en_b=1; RAMP/DEISO/ON/ISO: hdr_en_b=0.
REQ-016 iso_en=0 only in DEISO and ON; dut_rst=0 only in ON; pwr_ack=1 only in ON; fault=1 only in FAULT.
REQ-017 Counter loaded on every state entry with the dwell of the new state minus 1 (RAMP/DRAIN: RAMP_CYC-1; DEISO/ISO: ISO_CYC-1); decrements each cycle; timed states exit on the cycle the counter reads 0, so each timed state lasts exactly its parameter in cycles.
REQ-018 OFF -> RAMP when pwr_req=1.
REQ-019 RAMP at count 0: pgood=1 -> DEISO; pgood=0 -> FAULT.
REQ-020 RAMP with pwr_req=0 before expiry: abort to DRAIN immediately (next edge).
REQ-021 DEISO at count 0 -> ON; pwr_req deasserted during DEISO is ignored until ON.
REQ-022 ON -> ISO when pwr_req=0; ON -> FAULT when pgood=0 (pgood loss has priority over pwr_req=0).
REQ-023 ISO at count 0 -> DRAIN; DRAIN at count 0 -> OFF.
REQ-024 pwr_req reasserted during ISO or DRAIN does not abort; down sequence completes, then OFF re-enters RAMP on the following edge if pwr_req still 1.
REQ-025 FAULT -> OFF only when pwr_req=0; FAULT is sticky otherwise.
REQ-026 Latency: pwr_req rising sampled at edge k -> hdr_en_b=0 after k+1, iso_en=0 after k+1+RAMP_CYC, pwr_ack=1 after k+1+RAMP_CYC+ISO_CYC.
REQ-027 Power-down: pwr_req=0 sampled in ON at edge k -> pwr_ack=0, dut_rst=1, iso_en=1 after k+1; hdr_en_b=1 after k+1+ISO_CYC; OFF after k+1+ISO_CYC+RAMP_CYC.

Reset
REQ-028 rst=1 forces state OFF and counter 0 asynchronously: hdr_en_b=1, iso_en=1, dut_rst=1, pwr_ack=0, busy=0, fault=0.
REQ-029 rst asserted mid-sequence (any state) takes effect without waiting for clk; header opens immediately, no isolation-release glitch.
REQ-030 After rst deassertion FSM starts in OFF and honours a pwr_req already high on the first edge.

Verification (RAMP_CYC=4, ISO_CYC=2)
REQ-031 Power-up: pwr_req=1, pgood=1 sampled edge 0 -> hdr_en_b=0 after edge 1, iso_en=0 after edge 5, pwr_ack=1/dut_rst=0 after edge 7, busy=1 edges 1-6.
REQ-032 Power-down from ON: pwr_req=0 at edge 10 -> pwr_ack=0/iso_en=1 after edge 11, hdr_en_b=1 after edge 13, OFF (busy=0) after edge 17.
REQ-033 Ramp fault: pgood=0 throughout power-up -> FAULT after edge 5, hdr_en_b=1, fault=1; stays until pwr_req=0, then OFF next edge.
REQ-034 Abort: pwr_req drops at edge 2 in RAMP -> DRAIN after edge 3, hdr_en_b=1, OFF after edge 7, iso_en never 0.
REQ-035 Re-request in DRAIN: pwr_req returns to 1 during DRAIN -> OFF reached, RAMP entered next edge, full up-sequence repeats.
REQ-036 Async reset in ON: rst pulse between edges -> all outputs at reset values before next edge; pwr_ack=0 immediately.

Source files
------------

// File: rtl/power_seq_ctrl.sv
// Power-gating sequencer for a header-switched domain: ramps the PMOS header,
// checks pgood, releases isolation and reset on the way up, and reverses on the way down.
module power_seq_ctrl #(
   parameter int unsigned RAMP_CYC = 16,
   parameter int unsigned ISO_CYC  = 4,
   parameter int unsigned CNT_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic pwr_req,
   input  logic pgood,
   output logic hdr_en_b,
   output logic iso_en,
   output logic dut_rst,
   output logic pwr_ack,
   output logic busy,
   output logic fault
);

   typedef enum logic [2:0] {
      S_OFF,
      S_RAMP,
      S_DEISO,
      S_ON,
      S_ISO,
      S_DRAIN,
      S_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] RAMP_LD = CNT_W'(RAMP_CYC - 1);
   localparam logic [CNT_W-1:0] ISO_LD  = CNT_W'(ISO_CYC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             cnt_done;

   assign cnt_done = (cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_OFF;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_OFF:   if (pwr_req) state_nxt = S_RAMP;
         S_RAMP: begin
            // An abort request wins over ramp expiry.
            if (!pwr_req)     state_nxt = S_DRAIN;
            else if (cnt_done) state_nxt = pgood ? S_DEISO : S_FAULT;
         end
         S_DEISO: if (cnt_done) state_nxt = S_ON;
         S_ON: begin
            if (!pgood)        state_nxt = S_FAULT;
            else if (!pwr_req) state_nxt = S_ISO;
         end
         S_ISO:   if (cnt_done) state_nxt = S_DRAIN;
         S_DRAIN: if (cnt_done) state_nxt = S_OFF;
         S_FAULT: if (!pwr_req) state_nxt = S_OFF;
         default: state_nxt = S_OFF;
      endcase

      // Reload with the new state's dwell on every entry, otherwise count down to 0.
      if (state_nxt != state) begin
         case (state_nxt)
            S_RAMP, S_DRAIN: cnt_nxt = RAMP_LD;
            S_DEISO, S_ISO:  cnt_nxt = ISO_LD;
            default:         cnt_nxt = '0;
         endcase
      end else if (!cnt_done) begin
         cnt_nxt = cnt - 1'b1;
      end else begin
         cnt_nxt = cnt;
      end
   end

   always_comb begin
      hdr_en_b = 1'b1;
      iso_en   = 1'b1;
      dut_rst  = 1'b1;
      pwr_ack  = 1'b0;
      busy     = 1'b0;
      fault    = 1'b0;
      case (state)
         S_RAMP, S_ISO: begin
            hdr_en_b = 1'b0;
            busy     = 1'b1;
         end
         S_DEISO: begin
            hdr_en_b = 1'b0;
            iso_en   = 1'b0;
            busy     = 1'b1;
         end
         S_ON: begin
            hdr_en_b = 1'b0;
            iso_en   = 1'b0;
            dut_rst  = 1'b0;
            pwr_ack  = 1'b1;
         end
         S_DRAIN: busy  = 1'b1;
         S_FAULT: fault = 1'b1;
         default: ;
      endcase
   end

endmodule
